// File: rtl/l1c_pkg.sv
// l1c_pkg: shared FSM state type and address-field width helpers for the instruction cache
package l1c_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;
  localparam int BYTE_W = 2;
  function automatic int fld_w(input int n);
    return n > 1 ? $clog2(n) : 0;
  endfunction
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/l1c_way_match.sv
// l1c_way_match: tag compare across ways; ports tag/way_tags/way_valid in, hit and lowest matching way out
module l1c_way_match #(
  parameter int WAYS = 2,
  parameter int TW = 22,
  parameter int WW = 1
) (
  input  logic [TW-1:0]      tag,
  input  logic [WAYS*TW-1:0] way_tags,
  input  logic [WAYS-1:0]    way_valid,
  output logic               hit,
  output logic [WW-1:0]      way
);
  always_comb begin
    hit = 1'b0;
    way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (way_valid[w] && way_tags[w*TW +: TW] == tag) begin
        hit = 1'b1;
        way = WW'(w);
      end
  end
endmodule

// File: rtl/l1c_inst_assoc.sv
// l1c_inst_assoc: set-associative instruction cache with flop storage and word-by-word line fill
// ports: clk, rst (async, active-high); core_req/core_addr/flush in, core_out/core_wait out;
//        I_req/I_addr out, I_out/I_wait in (memory side); hit_cnt/miss_cnt saturating counters
module l1c_inst_assoc
  import l1c_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] core_out,
  output logic              core_wait,
  output logic              I_req,
  output logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_out,
  input  logic              I_wait,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int OW = fld_w(WORDS);
  localparam int IW = fld_w(SETS);
  localparam int TW = ADDR_W - BYTE_W - OW - IW;
  localparam int WW = sel_w(WAYS);
  localparam int CW = sel_w(WORDS);
  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [WW-1:0]     vway, hway, victim, inv_way;
  logic [CW-1:0]     wcnt, wsel;
  logic              flush_pending, hit, inv_found, lk_hit, last;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag_q;
  logic [WAYS*TW-1:0] way_tags;
  logic [WAYS-1:0]   valid [SETS];
  logic [WW-1:0]     vptr [SETS];
  logic [TW-1:0]     tags [SETS][WAYS];
  logic [DATA_W-1:0] data [SETS][WAYS][WORDS];
  assign idx = addr_q[BYTE_W+OW +: IW];
  assign tag_q = addr_q[ADDR_W-1 -: TW];
  assign wsel = CW'(addr_q >> BYTE_W) & CW'(WORDS - 1);
  assign last = wcnt == CW'(WORDS - 1);
  always_comb begin
    way_tags = '0;
    inv_found = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_tags[w*TW +: TW] = tags[idx][w];
      if (!valid[idx][w]) begin
        inv_found = 1'b1;
        inv_way = WW'(w);
      end
    end
  end
  l1c_way_match #(.WAYS(WAYS), .TW(TW), .WW(WW)) u_match (
    .tag(tag_q),
    .way_tags(way_tags),
    .way_valid(valid[idx]),
    .hit(hit),
    .way(hway)
  );
  assign victim = inv_found ? inv_way : vptr[idx];
  assign lk_hit = state == LOOKUP && hit;
  assign core_out = lk_hit ? data[idx][hway][wsel] : state == RESP ? data[idx][vway][wsel] : '0;
  assign core_wait = core_req & ~(lk_hit | state == RESP);
  assign I_req = state == FILL;
  assign I_addr = I_req ? (addr_q & ~ADDR_W'(WORDS * 4 - 1)) | (ADDR_W'(wcnt) << BYTE_W) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      flush_pending <= 1'b0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      addr_q <= '0;
      vway <= '0;
      wcnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        vptr[s] <= '0;
      end
    end else begin
      if (flush && state != IDLE) flush_pending <= 1'b1;
      case (state)
        IDLE:
          if (flush || flush_pending) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
            flush_pending <= 1'b0;
          end else if (core_req) begin
            addr_q <= core_addr;
            state <= LOOKUP;
          end
        LOOKUP:
          if (hit) begin
            hit_cnt <= hit_cnt + 32'(hit_cnt != '1);
            state <= IDLE;
          end else begin
            miss_cnt <= miss_cnt + 32'(miss_cnt != '1);
            vway <= victim;
            // the victim stays invalid until its last word lands, so an abandoned fill never hits
            valid[idx][victim] <= 1'b0;
            if (!inv_found) vptr[idx] <= vptr[idx] == WW'(WAYS - 1) ? '0 : vptr[idx] + 1'b1;
            wcnt <= '0;
            state <= FILL;
          end
        FILL:
          if (!I_wait) begin
            wcnt <= wcnt + 1'b1;
            if (last) begin
              valid[idx][vway] <= 1'b1;
              state <= RESP;
            end
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (state == FILL && !I_wait) begin
      data[idx][vway][wcnt] <= I_out;
      if (last) tags[idx][vway] <= tag_q;
    end
endmodule

// File: tb/tb_l1c_inst_assoc.sv
// tb_l1c_inst_assoc: randomized and directed checks of l1c_inst_assoc against an abstract cache model
module tb_l1c_inst_assoc;
  logic clk = 1'b0, rst = 1'b1, core_req = 1'b1, flush = 1'b0, I_wait = 1'b0;
  logic [31:0] core_addr = '0, core_out, I_addr, I_out, hit_cnt, miss_cnt;
  logic core_wait, I_req;
  int total = 0, bad = 0;
  bit rand_stall = 1'b1;
  logic [31:0] stall_addr = '1;
  int stall_left = 0;
  logic [31:0] log_q[$];
  bit mval[64][2];
  logic [21:0] mtag[64][2];
  int mptr[64];
  int exp_hits = 0, exp_misses = 0;

  l1c_inst_assoc dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_addr(core_addr), .flush(flush),
    .core_out(core_out), .core_wait(core_wait), .I_req(I_req), .I_addr(I_addr),
    .I_out(I_out), .I_wait(I_wait), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction
  assign I_out = mem(I_addr);

  always @(negedge clk) begin
    if (I_req && I_addr == stall_addr && stall_left > 0) begin
      I_wait = 1'b1;
      stall_left--;
    end else I_wait = rand_stall && ($urandom_range(0, 3) == 0);
    #1;
    if (I_req && !I_wait) log_q.push_back(I_addr);
  end

  function automatic bit m_hit(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (mval[a[9:4]][w] && mtag[a[9:4]][w] == a[31:10]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_access(input logic [31:0] a);
    int i, v;
    i = int'(a[9:4]);
    if (m_hit(a)) begin
      exp_hits++;
      return;
    end
    exp_misses++;
    if (!mval[i][0]) v = 0;
    else if (!mval[i][1]) v = 1;
    else begin
      v = mptr[i];
      mptr[i] = (mptr[i] + 1) % 2;
    end
    mval[i][v] = 1'b1;
    mtag[i][v] = a[31:10];
  endtask

  task automatic m_flush();
    for (int s = 0; s < 64; s++) begin
      mval[s][0] = 1'b0;
      mval[s][1] = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_flush();
    for (int s = 0; s < 64; s++) mptr[s] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic pulse_flush();
    @(negedge clk); #2;
    flush = 1'b1;
    @(negedge clk); #2;
    flush = 1'b0;
    m_flush();
  endtask

  task automatic access(input logic [31:0] a, input bit exp_hit);
    int lat;
    bit got;
    logic [31:0] d, base;
    @(negedge clk); #2;
    log_q.delete();
    core_addr = a;
    core_req = 1'b1;
    lat = 0;
    got = 1'b0;
    d = '0;
    while (!got && lat < 200) begin
      @(negedge clk); #2;
      lat++;
      if (!core_wait) begin
        got = 1'b1;
        d = core_out;
      end
    end
    core_req = 1'b0;
    m_access(a);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL timeout addr=%h core_wait=%b want 0 within 200 cycles", a, core_wait);
      return;
    end
    total++;
    if ((log_q.size() == 0) !== exp_hit) begin
      bad++;
      $display("FAIL hit_flag addr=%h got=%0d want=%0d", a, log_q.size() == 0, exp_hit);
    end
    total++;
    if (d !== mem(a)) begin
      bad++;
      $display("FAIL data addr=%h got=%h want=%h", a, d, mem(a));
    end
    if (exp_hit) begin
      total++;
      if (lat != 1) begin
        bad++;
        $display("FAIL hit_latency addr=%h got=%0d want=1", a, lat);
      end
    end else begin
      base = a & ~32'hF;
      total++;
      if (log_q.size() != 4) begin
        bad++;
        $display("FAIL fill_len addr=%h got=%0d want=4", a, log_q.size());
      end else
        for (int k = 0; k < 4; k++) begin
          total++;
          if (log_q[k] !== base + 32'(4 * k)) begin
            bad++;
            $display("FAIL fill_addr k=%0d got=%h want=%h", k, log_q[k], base + 32'(4 * k));
          end
        end
    end
    @(negedge clk); #2;
    total++;
    if (hit_cnt !== 32'(exp_hits)) begin
      bad++;
      $display("FAIL hit_cnt got=%0d want=%0d", hit_cnt, exp_hits);
    end
    total++;
    if (miss_cnt !== 32'(exp_misses)) begin
      bad++;
      $display("FAIL miss_cnt got=%0d want=%0d", miss_cnt, exp_misses);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (core_wait !== 1'b1 || I_req !== 1'b0 || core_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs core_wait=%b I_req=%b core_out=%h want 1 0 0", core_wait, I_req, core_out);
    end
    total++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      bad++;
      $display("FAIL reset_counters hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
    end
    core_req = 1'b0;
    #1;
    total++;
    if (core_wait !== 1'b0) begin
      bad++;
      $display("FAIL reset_wait_follows_req got=%b want=0", core_wait);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #2;
  endtask

  task automatic test_cold_hit_flush();
    access(32'h100, 1'b0);
    access(32'h108, 1'b1);
    pulse_flush();
    access(32'h108, 1'b0);
  endtask

  task automatic test_evict();
    access(32'h100, 1'b1);
    access(32'h500, 1'b0);
    access(32'h900, 1'b0);
    access(32'h500, 1'b1);
    access(32'h100, 1'b0);
  endtask

  task automatic test_stall();
    int n;
    pulse_flush();
    rand_stall = 1'b0;
    stall_addr = 32'h108;
    stall_left = 10;
    log_q.delete();
    core_addr = 32'h100;
    core_req = 1'b1;
    n = 0;
    while (!(I_req && I_addr == 32'h108) && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (I_req !== 1'b1 || I_addr !== 32'h108 || core_wait !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold i=%0d I_req=%b I_addr=%h core_wait=%b want 1 00000108 1", i, I_req, I_addr, core_wait);
      end
      @(negedge clk); #2;
    end
    n = 0;
    while (core_wait && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    total++;
    if (core_wait !== 1'b0 || core_out !== mem(32'h100)) begin
      bad++;
      $display("FAIL stall_resp core_wait=%b core_out=%h want 0 %h", core_wait, core_out, mem(32'h100));
    end
    core_req = 1'b0;
    total++;
    if (log_q.size() != 4 || log_q[2] !== 32'h108 || log_q[3] !== 32'h10C) begin
      bad++;
      $display("FAIL stall_fill_order n=%0d want 4 ending 108 10c", log_q.size());
    end
    m_access(32'h100);
    stall_addr = '1;
    rand_stall = 1'b1;
  endtask

  task automatic test_flush_pending();
    int n;
    pulse_flush();
    @(negedge clk); #2;
    core_addr = 32'h300;
    core_req = 1'b1;
    n = 0;
    while (!I_req && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    total++;
    if (I_req !== 1'b1) begin
      bad++;
      $display("FAIL fp_no_fill I_req=%b want 1", I_req);
    end
    flush = 1'b1;
    @(negedge clk); #2;
    flush = 1'b0;
    n = 0;
    while (core_wait && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    total++;
    if (core_wait !== 1'b0 || core_out !== mem(32'h300)) begin
      bad++;
      $display("FAIL fp_resp core_wait=%b core_out=%h want 0 %h", core_wait, core_out, mem(32'h300));
    end
    core_req = 1'b0;
    m_access(32'h300);
    m_flush();
    access(32'h300, 1'b0);
    access(32'h300, 1'b1);
  endtask

  task automatic test_reset_fill();
    int n;
    pulse_flush();
    rand_stall = 1'b0;
    @(negedge clk); #2;
    core_addr = 32'h100;
    core_req = 1'b1;
    n = 0;
    while (!(I_req && I_addr == 32'h108) && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (I_req !== 1'b0 || core_wait !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_fill I_req=%b core_wait=%b want 0 1", I_req, core_wait);
    end
    total++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      bad++;
      $display("FAIL rst_in_fill_cnt hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
    end
    core_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    m_reset();
    rand_stall = 1'b1;
    access(32'h100, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 11) == 0) pulse_flush();
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      access(a, m_hit(a));
    end
  endtask

  initial begin
    test_reset();
    test_cold_hit_flush();
    test_evict();
    test_stall();
    test_flush_pending();
    test_reset_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
